// File: rtl/wb_store_pkg.sv
// wb_store_pkg: shared definitions for the committed-store queue.
//   TAG_W / STORE_TAG : dCache request tag carried by every store request
//   drainState_e      : states of the drain FSM in wb_store_queue
//   storeEntry_t      : one queued store at the default 64-bit address/data width
package wb_store_pkg;

  // dCache bus tag fields: {op, space, kind, 7-bit id}
  localparam int TAG_W = 10;

  localparam logic TAG_OP_READ      = 1'b0;
  localparam logic TAG_OP_WRITE     = 1'b1;
  localparam logic TAG_SPACE_MEMORY = 1'b0;
  localparam logic TAG_SPACE_IO     = 1'b1;
  localparam logic TAG_KIND_INSTR   = 1'b0;
  localparam logic TAG_KIND_DATA    = 1'b1;

  localparam logic [TAG_W-1:0] STORE_TAG =
    {TAG_OP_WRITE, TAG_SPACE_MEMORY, TAG_KIND_DATA, 7'b0};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } drainState_e;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
  } storeEntry_t;

endpackage

// File: rtl/wb_store_fifo.sv
// wb_store_fifo: circular store buffer with youngest-match lookup.
//   enq/enqAddr/enqData : write one entry at tail (caller guarantees !full)
//   pop                 : retire head entry (caller guarantees !empty)
//   headAddr/headData   : oldest entry
//   lookupAddr -> lookupHit/lookupData : youngest valid entry with equal address
//   count/empty/full    : occupancy
module wb_store_fifo
  import wb_store_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enq,
  input  logic [ADDR_W-1:0] enqAddr,
  input  logic [DATA_W-1:0] enqData,
  input  logic              pop,
  output logic [ADDR_W-1:0] headAddr,
  output logic [DATA_W-1:0] headData,
  input  logic [ADDR_W-1:0] lookupAddr,
  output logic              lookupHit,
  output logic [DATA_W-1:0] lookupData,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full
);

  logic [ADDR_W-1:0] addrMem [DEPTH];
  logic [DATA_W-1:0] dataMem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + PTR_W'(1);
      if (pop) head <= head + PTR_W'(1);
      case ({enq, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: count alone decides which slots are valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      addrMem[tail] <= enqAddr;
      dataMem[tail] <= enqData;
    end
  end

  assign headAddr = addrMem[head];
  assign headData = dataMem[head];
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));

  // Walk from oldest to youngest so the last match (closest to tail) wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx        = '0;
    lookupHit  = 1'b0;
    lookupData = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if ((CNT_W'(k) < count) && (addrMem[idx] == lookupAddr)) begin
        lookupHit  = 1'b1;
        lookupData = dataMem[idx];
      end
    end
  end

endmodule

// File: rtl/wb_store_queue.sv
// wb_store_queue: committed-store buffer between write-back and the dCache.
//   enqValidIn/enqAddrIn/enqDataIn/enqReadyOut : store enqueue from write-back
//   reqcycOut/reqOut/reqdataOut/reqtagOut      : registered dCache write request
//   reqackIn/writeackIn                        : dCache accept / write done
//   lookupAddrIn -> lookupHitOut/lookupDataOut : store-to-load forwarding
//   countOut/emptyOut/fullOut                  : occupancy
// Drain FSM:
//   S_IDLE | no request outstanding; launch head entry if queue non-empty
//   S_REQ  | reqcycOut high, waiting for reqackIn
//   S_WAIT | request accepted, waiting for writeackIn to retire head
module wb_store_queue
  import wb_store_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enqValidIn,
  input  logic [ADDR_W-1:0]      enqAddrIn,
  input  logic [DATA_W-1:0]      enqDataIn,
  output logic                   enqReadyOut,
  output logic                   reqcycOut,
  output logic [ADDR_W-1:0]      reqOut,
  output logic [DATA_W-1:0]      reqdataOut,
  output logic [TAG_W-1:0]       reqtagOut,
  input  logic                   reqackIn,
  input  logic                   writeackIn,
  input  logic [ADDR_W-1:0]      lookupAddrIn,
  output logic                   lookupHitOut,
  output logic [DATA_W-1:0]      lookupDataOut,
  output logic [$clog2(DEPTH):0] countOut,
  output logic                   emptyOut,
  output logic                   fullOut
);

  drainState_e       state;
  logic              enqFire;
  logic              popFire;
  logic [ADDR_W-1:0] headAddr;
  logic [DATA_W-1:0] headData;

  assign enqReadyOut = !fullOut;
  assign enqFire     = enqValidIn && !fullOut;
  // Head retires only on writeack; same-cycle reqack+writeack in S_REQ counts.
  assign popFire     = ((state == S_REQ) && reqackIn && writeackIn) ||
                       ((state == S_WAIT) && writeackIn);

  wb_store_fifo #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) uFifo (
    .clk       (clk),
    .reset     (reset),
    .enq       (enqFire),
    .enqAddr   (enqAddrIn),
    .enqData   (enqDataIn),
    .pop       (popFire),
    .headAddr  (headAddr),
    .headData  (headData),
    .lookupAddr(lookupAddrIn),
    .lookupHit (lookupHitOut),
    .lookupData(lookupDataOut),
    .count     (countOut),
    .empty     (emptyOut),
    .full      (fullOut)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      reqcycOut  <= 1'b0;
      reqOut     <= '0;
      reqdataOut <= '0;
      reqtagOut  <= STORE_TAG;
    end else begin
      reqtagOut <= STORE_TAG;
      case (state)
        S_IDLE: begin
          if (!emptyOut) begin
            reqcycOut  <= 1'b1;
            reqOut     <= headAddr;
            reqdataOut <= headData;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (reqackIn) begin
            reqcycOut <= 1'b0;
            state     <= writeackIn ? S_IDLE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (writeackIn) state <= S_IDLE;
        end
        default: begin
          reqcycOut <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
